// File: rtl/mem_access_unit_pkg.sv
// Shared definitions for the memory access stage.
// Holds the operator codes, write/reset polarity constants, the FSM state
// encodings, the access-size encoding and the big-endian lane mask helper.
package mem_access_unit_pkg;

    // Operator codes (8-bit, as carried in the EX/MEM register)
    localparam logic [7:0] OP_NOP = 8'h00;
    localparam logic [7:0] OP_ADD = 8'h01;
    localparam logic [7:0] OP_SUB = 8'h02;
    localparam logic [7:0] OP_LB  = 8'h20;
    localparam logic [7:0] OP_LBU = 8'h21;
    localparam logic [7:0] OP_LH  = 8'h22;
    localparam logic [7:0] OP_LHU = 8'h23;
    localparam logic [7:0] OP_LW  = 8'h24;
    localparam logic [7:0] OP_SB  = 8'h28;
    localparam logic [7:0] OP_SH  = 8'h29;
    localparam logic [7:0] OP_SW  = 8'h2A;

    localparam logic WRITE_ENABLE  = 1'b1;
    localparam logic WRITE_DISABLE = 1'b0;
    localparam logic RESET_ENABLE  = 1'b1;

    typedef enum logic [1:0] {
        STATE_IDLE = 2'd0,
        STATE_BUSY = 2'd1,
        STATE_DONE = 2'd2
    } state_t;

    typedef enum logic [1:0] {
        SIZE_BYTE = 2'd0,
        SIZE_HALF = 2'd1,
        SIZE_WORD = 2'd2
    } access_size_t;

    // Big-endian lane mask: offset 0 is the most significant byte (bit 3).
    function automatic logic [3:0] lane_mask(input logic [1:0] size, input logic [1:0] offset);
        logic [3:0] mask;
        case (size)
            SIZE_BYTE: mask = 4'b1000 >> offset;
            SIZE_HALF: mask = offset[1] ? 4'b0011 : 4'b1100;
            default:   mask = 4'b1111;
        endcase
        return mask;
    endfunction

endpackage

// File: rtl/mem_access_unit_load_aligner.sv
// load_aligner: selects the addressed lane of a big-endian bus word and
// sign- or zero-extends it to 32 bits. Purely combinational.
// Ports:
//   load_size   - access size (SIZE_BYTE / SIZE_HALF / SIZE_WORD)
//   load_signed - 1 sign-extends, 0 zero-extends
//   byte_offset - address bits [1:0]
//   read_data   - captured bus word
//   load_data   - extracted, extended result
module load_aligner
    import mem_access_unit_pkg::*;
(
    input  logic [1:0]  load_size,
    input  logic        load_signed,
    input  logic [1:0]  byte_offset,
    input  logic [31:0] read_data,
    output logic [31:0] load_data
);

    logic [7:0]  lane_byte;
    logic [15:0] lane_half;

    always_comb begin
        case (byte_offset)
            2'd0:    lane_byte = read_data[31:24];
            2'd1:    lane_byte = read_data[23:16];
            2'd2:    lane_byte = read_data[15:8];
            default: lane_byte = read_data[7:0];
        endcase
        lane_half = byte_offset[1] ? read_data[15:0] : read_data[31:16];

        case (load_size)
            SIZE_BYTE: load_data = {{24{load_signed & lane_byte[7]}}, lane_byte};
            SIZE_HALF: load_data = {{16{load_signed & lane_half[15]}}, lane_half};
            default:   load_data = read_data;
        endcase
    end

endmodule

// File: rtl/mem_access_unit.sv
// mem_access_unit: MEM pipeline stage. Non-memory operations pass straight
// through to write-back; loads/stores run a single bus transaction through
// an IDLE -> BUSY -> DONE FSM while stalling the earlier stages.
// Ports:
//   clock, reset           - rising-edge clock, synchronous active-high reset
//   mem_*                  - EX/MEM register outputs (operator, address, store
//                            data, write-back enable/address/ALU result)
//   wb_reg_write_*         - to the MEM/WB register
//   bus_*                  - data bus; request/address/lanes/data are registered
//   stall_request          - freezes stages 0-3 while a memory access is pending
//   address_error          - combinational misalignment flag in IDLE
module mem_access_unit
    import mem_access_unit_pkg::*;
(
    input  logic        clock,
    input  logic        reset,
    input  logic [7:0]  mem_operator,
    input  logic [31:0] mem_operand_a,
    input  logic [31:0] mem_operand_b,
    input  logic        mem_reg_write_enable,
    input  logic [4:0]  mem_reg_write_address,
    input  logic [31:0] mem_reg_write_data,
    output logic        wb_reg_write_enable,
    output logic [4:0]  wb_reg_write_address,
    output logic [31:0] wb_reg_write_data,
    output logic        bus_request,
    output logic        bus_write_enable,
    output logic [31:0] bus_address,
    output logic [3:0]  bus_byte_select,
    output logic [31:0] bus_write_data,
    input  logic        bus_ready,
    input  logic [31:0] bus_read_data,
    output logic        stall_request,
    output logic        address_error
);

    state_t       state_q, state_d;
    access_size_t access_size;
    logic         is_load, is_store, is_mem, load_signed;
    logic         misaligned, mem_aligned;
    logic [31:0]  store_data;
    logic [31:0]  read_data_q;
    logic [31:0]  load_data;

    // Operator decode
    always_comb begin
        is_load     = 1'b0;
        is_store    = 1'b0;
        load_signed = 1'b0;
        access_size = SIZE_WORD;
        case (mem_operator)
            OP_LB:  begin is_load  = 1'b1; access_size = SIZE_BYTE; load_signed = 1'b1; end
            OP_LBU: begin is_load  = 1'b1; access_size = SIZE_BYTE; end
            OP_LH:  begin is_load  = 1'b1; access_size = SIZE_HALF; load_signed = 1'b1; end
            OP_LHU: begin is_load  = 1'b1; access_size = SIZE_HALF; end
            OP_LW:  begin is_load  = 1'b1; access_size = SIZE_WORD; end
            OP_SB:  begin is_store = 1'b1; access_size = SIZE_BYTE; end
            OP_SH:  begin is_store = 1'b1; access_size = SIZE_HALF; end
            OP_SW:  begin is_store = 1'b1; access_size = SIZE_WORD; end
            default: ;
        endcase
    end

    assign is_mem      = is_load | is_store;
    assign misaligned  = ((access_size == SIZE_HALF) && mem_operand_a[0]) ||
                         ((access_size == SIZE_WORD) && (mem_operand_a[1:0] != 2'b00));
    assign mem_aligned = is_mem && !misaligned;

    // Stores replicate the datum across every lane; byte_select picks the live one.
    always_comb begin
        case (access_size)
            SIZE_BYTE: store_data = {4{mem_operand_b[7:0]}};
            SIZE_HALF: store_data = {2{mem_operand_b[15:0]}};
            default:   store_data = mem_operand_b;
        endcase
    end

    // FSM state register
    always_ff @(posedge clock) begin
        if (reset == RESET_ENABLE) state_q <= STATE_IDLE;
        else                       state_q <= state_d;
    end

    // FSM next state and control outputs
    always_comb begin
        state_d       = state_q;
        stall_request = mem_aligned && (state_q != STATE_DONE);
        address_error = is_mem && misaligned && (state_q == STATE_IDLE);
        case (state_q)
            STATE_IDLE: if (mem_aligned) state_d = STATE_BUSY;
            STATE_BUSY: if (bus_ready)   state_d = STATE_DONE;
            STATE_DONE: state_d = STATE_IDLE;
            default:    state_d = STATE_IDLE;
        endcase
    end

    // Bus registers: loaded on IDLE->BUSY, held until bus_ready ends the access.
    // The captured read word is only written from BUSY, so bus traffic in any
    // other state is ignored.
    always_ff @(posedge clock) begin
        if (reset == RESET_ENABLE) begin
            bus_request      <= 1'b0;
            bus_write_enable <= 1'b0;
            bus_address      <= 32'd0;
            bus_byte_select  <= 4'd0;
            bus_write_data   <= 32'd0;
            read_data_q      <= 32'd0;
        end else begin
            case (state_q)
                STATE_IDLE: if (mem_aligned) begin
                    bus_request      <= 1'b1;
                    bus_write_enable <= is_store;
                    bus_address      <= {mem_operand_a[31:2], 2'b00};
                    bus_byte_select  <= lane_mask(access_size, mem_operand_a[1:0]);
                    bus_write_data   <= store_data;
                end
                STATE_BUSY: if (bus_ready) begin
                    bus_request      <= 1'b0;
                    bus_write_enable <= 1'b0;
                    read_data_q      <= bus_read_data;
                end
                default: ;
            endcase
        end
    end

    // The EX/MEM register is frozen during the access, so operand_a's low
    // bits are still valid in DONE for lane selection.
    load_aligner u_load_aligner (
        .load_size   (access_size),
        .load_signed (load_signed),
        .byte_offset (mem_operand_a[1:0]),
        .read_data   (read_data_q),
        .load_data   (load_data)
    );

    // Write-back: pass-through for ALU ops; memory ops only write in DONE for loads.
    always_comb begin
        wb_reg_write_enable  = mem_reg_write_enable;
        wb_reg_write_address = mem_reg_write_address;
        wb_reg_write_data    = mem_reg_write_data;
        if (is_mem) begin
            wb_reg_write_enable = WRITE_DISABLE;
            if ((state_q == STATE_DONE) && is_load && !misaligned) begin
                wb_reg_write_enable = mem_reg_write_enable;
                wb_reg_write_data   = load_data;
            end
        end
    end

endmodule
